// File: rtl/keypad_scanner_if.sv
// Keypad scanner signal bundle: the matrix side (rows in, column strobes out)
// and the user side (accepted key, press strobe, hold flag, two-digit guess).
interface keypad_scanner_if;
  logic [3:0] row_i;        // keypad rows, active-low, asynchronous
  logic [3:0] col_o;        // column strobes, active-low, one-cold
  logic [3:0] key_o;        // hex code of the last accepted key
  logic       key_valid_o;  // one-cycle strobe per accepted press
  logic       key_held_o;   // high from accepted press to accepted release
  logic [7:0] guess_o;      // {previous, latest} accepted keys

  // Scanner side: reads rows, drives everything else.
  modport master (
    input  row_i,
    output col_o,
    output key_o,
    output key_valid_o,
    output key_held_o,
    output guess_o
  );

  // Consumer / keypad-model side.
  modport slave (
    output row_i,
    input  col_o,
    input  key_o,
    input  key_valid_o,
    input  key_held_o,
    input  guess_o
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: drives one column low at a time, captures the rows
// for every column, classifies each full sweep, debounces whole sweeps and
// reports accepted presses with a one-cycle strobe plus a two-digit history.
module keypad_scanner #(
  parameter int SCAN_TICKS     = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic          clk,
  input  logic          rst,
  keypad_scanner_if.master kp
);

  localparam int          TW  = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [3:0]  DEB = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // Scan timing and column strobes
  logic [TW-1:0]    tick_q;
  logic [1:0]       col_q;
  logic [3:0]       colbar_q;
  // Row synchronizer and per-column captures (column 3 is taken live)
  logic [3:0]       row_meta_q;
  logic [3:0]       row_sync_q;
  logic [2:0][3:0]  cap_q;
  // Debounce FSM and outputs
  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       key_q, key_d;
  logic             valid_q, valid_d;
  logic             held_q, held_d;
  logic [7:0]       guess_q, guess_d;

  logic             tick_done;
  logic             sweep_done;
  logic [3:0][3:0]  col_rows;
  logic [15:0]      hits;
  logic [4:0]       hit_cnt;
  logic [3:0]       hit_idx;
  logic             res_none;
  logic             res_single;
  logic [3:0]       res_key;
  logic             accept;

  // Key map, index = row*4 + col.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] k;
    case (idx)
      4'd0:  k = 4'h1;
      4'd1:  k = 4'h2;
      4'd2:  k = 4'h3;
      4'd3:  k = 4'hA;
      4'd4:  k = 4'h4;
      4'd5:  k = 4'h5;
      4'd6:  k = 4'h6;
      4'd7:  k = 4'hB;
      4'd8:  k = 4'h7;
      4'd9:  k = 4'h8;
      4'd10: k = 4'h9;
      4'd11: k = 4'hC;
      4'd12: k = 4'h0;
      4'd13: k = 4'hF;
      4'd14: k = 4'hE;
      default: k = 4'hD;
    endcase
    return k;
  endfunction

  assign tick_done  = (tick_q == TICK_LAST);
  assign sweep_done = tick_done && (col_q == 2'd3);

  // Two-flop synchronizer on the asynchronous rows; idle level is all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
    end else begin
      row_meta_q <= kp.row_i;
      row_sync_q <= row_meta_q;
    end
  end

  // Tick counter and column rotation; the one-cold strobe is kept registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_q   <= '0;
      col_q    <= 2'd0;
      colbar_q <= 4'b1110;
    end else if (tick_done) begin
      tick_q   <= '0;
      col_q    <= col_q + 2'd1;
      colbar_q <= {colbar_q[2:0], colbar_q[3]};
    end else begin
      tick_q   <= tick_q + TW'(1);
    end
  end

  // Capture rows for columns 0..2 at the last tick of each column period.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap_q <= '1;
    end else if (tick_done) begin
      for (int c = 0; c < 3; c++) begin
        if (col_q == 2'(c)) cap_q[c] <= row_sync_q;
      end
    end
  end

  // Column 3 result is the live synchronized rows so the sweep can be
  // classified on the very edge that completes it.
  assign col_rows = {row_sync_q, cap_q[2], cap_q[1], cap_q[0]};

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_hit
      assign hits[gi] = ~col_rows[gi % 4][gi / 4];
    end
  endgenerate

  // Count intersections and remember the index of the (only) hit.
  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (hits[i]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = 4'(i);
      end
    end
  end

  assign res_none   = (hit_cnt == 5'd0);
  assign res_single = (hit_cnt == 5'd1);
  assign res_key    = key_map(hit_idx);

  // Debounce FSM next-state and output updates, evaluated only on sweep done.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    key_d   = key_q;
    valid_d = 1'b0;
    held_d  = held_q;
    guess_d = guess_q;
    accept  = 1'b0;
    if (sweep_done) begin
      case (state_q)
        IDLE: begin
          if (res_single) begin
            cand_d = res_key;
            cnt_d  = 4'd1;
            if (DEB == 4'd1) accept = 1'b1;
            else state_d = PRESS_WAIT;
          end
        end
        PRESS_WAIT: begin
          if (res_single && res_key == cand_q) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB) accept = 1'b1;
          end else if (res_single) begin
            cand_d = res_key;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (!(res_single && res_key == cand_q)) begin
            cnt_d   = 4'd1;
            state_d = RELEASE_WAIT;
            if (DEB == 4'd1 && res_none) begin
              held_d  = 1'b0;
              state_d = IDLE;
            end
          end
        end
        RELEASE_WAIT: begin
          if (res_none) begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_q + 4'd1 == DEB) begin
              held_d  = 1'b0;
              state_d = IDLE;
            end
          end else if (res_single && res_key == cand_q) begin
            state_d = HELD;
          end else begin
            // Other key or ghosting: restart the release count.
            cnt_d = 4'd0;
          end
        end
        default: state_d = IDLE;
      endcase
      if (accept) begin
        key_d   = cand_d;
        valid_d = 1'b1;
        guess_d = {guess_q[3:0], cand_d};
        held_d  = 1'b1;
        state_d = HELD;
      end
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      key_q   <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
      guess_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      key_q   <= key_d;
      valid_q <= valid_d;
      held_q  <= held_d;
      guess_q <= guess_d;
    end
  end

  assign kp.col_o       = colbar_q;
  assign kp.key_o       = key_q;
  assign kp.key_valid_o = valid_q;
  assign kp.key_held_o  = held_q;
  assign kp.guess_o     = guess_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Testbench for keypad_scanner: a keypad matrix model drives rows from the
// column strobes; a per-sweep behavioural model predicts the outputs.
module tb_keypad_scanner;

  localparam int ST  = 4;
  localparam int DEB = 3;
  localparam int SWEEP = 4 * ST;

  localparam int M_IDLE = 0, M_PW = 1, M_HELD = 2, M_RW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] pressed = '0;   // bit index = row*4 + col

  int checks = 0;
  int failures = 0;

  // Model state
  int          m_state;
  int          m_cnt;
  logic [3:0]  m_cand;
  logic [3:0]  m_key;
  logic        m_held;
  logic        m_valid;
  logic [7:0]  m_guess;

  logic [3:0] hex_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'h0, 4'hF, 4'hE, 4'hD};

  keypad_scanner_if kp ();

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_SCANS(DEB)) dut (
    .clk (clk),
    .rst (rst),
    .kp  (kp)
  );

  always #5 clk = ~clk;

  // Physical matrix: a row is pulled low when a pressed key joins it to the
  // column currently driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      kp.row_i[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (kp.col_o[c] == 1'b0 && pressed[r*4+c]) kp.row_i[r] = 1'b0;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] key_bit(input logic [3:0] hex);
    logic [15:0] m = '0;
    for (int i = 0; i < 16; i++) if (hex_tab[i] == hex) m[i] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_cnt = 0; m_cand = '0; m_key = '0;
    m_held = 1'b0; m_valid = 1'b0; m_guess = '0;
  endtask

  task automatic model_accept();
    m_key   = m_cand;
    m_valid = 1'b1;
    m_guess = {m_guess[3:0], m_cand};
    m_held  = 1'b1;
    m_state = M_HELD;
  endtask

  // Apply one whole-matrix sweep result to the model.
  task automatic model_sweep(input logic [15:0] mask);
    int n;
    bit single;
    bit same;
    logic [3:0] k;
    n = $countones(mask);
    single = (n == 1);
    k = '0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = hex_tab[i];
    same = single && (k == m_cand);
    m_valid = 1'b0;
    case (m_state)
      M_IDLE: if (single) begin
        m_cand = k; m_cnt = 1;
        if (DEB == 1) model_accept(); else m_state = M_PW;
      end
      M_PW: begin
        if (same) begin
          m_cnt++;
          if (m_cnt == DEB) model_accept();
        end else if (single) begin
          m_cand = k; m_cnt = 1;
        end else m_state = M_IDLE;
      end
      M_HELD: if (!same) begin
        m_cnt = 1; m_state = M_RW;
        if (DEB == 1 && n == 0) begin m_held = 1'b0; m_state = M_IDLE; end
      end
      default: begin
        if (n == 0) begin
          m_cnt++;
          if (m_cnt == DEB) begin m_held = 1'b0; m_state = M_IDLE; end
        end else if (same) m_state = M_HELD;
        else m_cnt = 0;
      end
    endcase
  endtask

  // Run one full sweep with a fixed set of pressed keys; called at a negedge
  // aligned with the start of a sweep.
  task automatic sweep(input logic [15:0] mask);
    logic [3:0] exp_col;
    pressed = mask;
    for (int i = 1; i <= SWEEP; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == SWEEP) model_sweep(mask);
      exp_col = ~(4'b0001 << ((i / ST) % 4));
      check_eq("col", 32'(kp.col_o), 32'(exp_col));
      check_eq("valid", 32'(kp.key_valid_o), (i == SWEEP) ? 32'(m_valid) : 32'd0);
    end
    check_eq("key", 32'(kp.key_o), 32'(m_key));
    check_eq("held", 32'(kp.key_held_o), 32'(m_held));
    check_eq("guess", 32'(kp.guess_o), 32'(m_guess));
    $display("sweep mask=%04h valid=%0d key=%0h held=%0d guess=%02h",
             mask, kp.key_valid_o, kp.key_o, kp.key_held_o, kp.guess_o);
  endtask

  task automatic sweeps(input logic [15:0] mask, input int n);
    for (int i = 0; i < n; i++) sweep(mask);
  endtask

  // Run part of a sweep (column checks only), then reset.
  task automatic reset_after(input int cycles, input logic [15:0] mask);
    logic [3:0] exp_col;
    for (int i = 1; i <= cycles; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_col = ~(4'b0001 << ((i / ST) % 4));
      check_eq("col_part", 32'(kp.col_o), 32'(exp_col));
    end
    pressed = mask;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
    check_eq("rst_col", 32'(kp.col_o), 32'h0000000e);
    check_eq("rst_key", 32'(kp.key_o), 32'd0);
    check_eq("rst_valid", 32'(kp.key_valid_o), 32'd0);
    check_eq("rst_held", 32'(kp.key_held_o), 32'd0);
    check_eq("rst_guess", 32'(kp.guess_o), 32'd0);
    $display("reset after %0d cycles mask=%04h", cycles, mask);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] m;
    int kind;
    model_reset();
    // Initial reset with nothing pressed.
    reset_after(0, '0);

    // Idle scanning for 13 sweeps (> 200 cycles): no press, columns rotate.
    sweeps('0, 13);

    // Hold "7" for ~300 cycles, then release.
    sweeps(key_bit(4'h7), 19);
    check_eq("key7", 32'(kp.key_o), 32'h7);
    check_eq("held7", 32'(kp.key_held_o), 32'd1);
    sweeps('0, 2);
    check_eq("held7_2none", 32'(kp.key_held_o), 32'd1);
    sweeps('0, 1);
    check_eq("held7_3none", 32'(kp.key_held_o), 32'd0);

    // Press 5, release, press C.
    sweeps(key_bit(4'h5), 4);
    sweeps('0, 4);
    sweeps(key_bit(4'hC), 4);
    check_eq("guess5C", 32'(kp.guess_o), 32'h5C);
    sweeps('0, 4);

    // Bouncing 3: alternate on/off, then stable.
    for (int i = 0; i < 4; i++) begin
      sweep(key_bit(4'h3));
      sweep('0);
    end
    sweeps(key_bit(4'h3), 3);
    check_eq("key3", 32'(kp.key_o), 32'h3);
    sweeps('0, 4);

    // 1 and 2 together never produce a key.
    sweeps(key_bit(4'h1) | key_bit(4'h2), 5);
    check_eq("multi_nohold", 32'(kp.key_held_o), 32'd0);
    sweeps('0, 2);
    // Hold 1, add 2, release both.
    sweeps(key_bit(4'h1), 4);
    sweeps(key_bit(4'h1) | key_bit(4'h2), 3);
    sweeps('0, 2);
    check_eq("multi_rel_2", 32'(kp.key_held_o), 32'd1);
    sweeps('0, 1);
    check_eq("multi_rel_3", 32'(kp.key_held_o), 32'd0);

    // Reset in HELD with 9 still pressed; 9 re-accepted 48 cycles later.
    sweeps(key_bit(4'h9), 4);
    reset_after(7, key_bit(4'h9));
    sweeps(key_bit(4'h9), 3);
    check_eq("key9_after_rst", 32'(kp.key_o), 32'h9);
    sweeps('0, 4);

    // Randomized segments, with occasional mid-sweep resets.
    for (int s = 0; s < 40; s++) begin
      kind = int'($urandom_range(0, 4));
      m = '0;
      if (kind == 1 || kind == 2) m[$urandom_range(0, 15)] = 1'b1;
      else if (kind == 3) begin
        m[$urandom_range(0, 7)] = 1'b1;
        m[$urandom_range(8, 15)] = 1'b1;
      end
      if (kind == 4 && $urandom_range(0, 2) == 0) reset_after(int'($urandom_range(1, SWEEP - 1)), m);
      else sweeps(m, int'($urandom_range(1, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
